// File: rtl/fpu_mant_div.sv
// fpu_mant_div: sequential restoring divider producing floor((a<<F)/b) and (a<<F) mod b
// One quotient bit per cycle; results are held in output registers until the next completion.
module fpu_mant_div #(
   parameter int W = 24,
   parameter int F = 24
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [W-1:0]     a_i,
   input  logic [W-1:0]     b_i,
   input  logic             ack_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic [W+F-1:0]   q_o,
   output logic [W-1:0]     r_o,
   output logic             sticky_o,
   output logic             dz_o
);
   localparam int N  = W + F;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

   state_t          r_state, w_next;
   logic [W-1:0]    r_a, r_b;
   logic [W:0]      r_pr;
   logic [N-1:0]    r_sh;
   logic [CW-1:0]   r_cnt;
   logic [N-1:0]    r_q;
   logic [W-1:0]    r_r;
   logic            r_sticky, r_dz;
   logic [W+1:0]    w_pr_sh, w_diff;
   logic            w_ge;
   logic [W:0]      w_pr_nx;
   logic [N-1:0]    w_sh_nx;

   // the sign of the widened difference decides the restoring step
   assign w_pr_sh = {r_pr, r_sh[N-1]};
   assign w_diff  = w_pr_sh - {2'b00, r_b};
   assign w_ge    = !w_diff[W+1];
   assign w_pr_nx = w_ge ? w_diff[W:0] : w_pr_sh[W:0];
   assign w_sh_nx = {r_sh[N-2:0], w_ge};

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = start_i ? S_LOAD : S_IDLE;
         S_LOAD:  w_next = abort_i ? S_IDLE : (r_b == '0) ? S_DONE : S_ITER;
         S_ITER:  w_next = abort_i ? S_IDLE : (r_cnt == CW'(1)) ? S_DONE : S_ITER;
         default: w_next = (ack_i || abort_i) ? S_IDLE : S_DONE;
      endcase
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_pr     <= '0;
         r_sh     <= '0;
         r_cnt    <= '0;
         r_q      <= '0;
         r_r      <= '0;
         r_sticky <= 1'b0;
         r_dz     <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && start_i) begin
            r_a <= a_i;
            r_b <= b_i;
         end
         if (r_state == S_LOAD) begin
            r_pr  <= '0;
            r_sh  <= N'(r_a) << F;
            r_cnt <= CW'(N);
         end
         if (r_state == S_ITER) begin
            r_pr  <= w_pr_nx;
            r_sh  <= w_sh_nx;
            r_cnt <= r_cnt - CW'(1);
         end
         // result registers change only on entry to DONE, so an abort leaves them untouched
         if (r_state == S_LOAD && w_next == S_DONE) begin
            r_q      <= '1;
            r_r      <= r_a;
            r_sticky <= |r_a;
            r_dz     <= 1'b1;
         end
         if (r_state == S_ITER && w_next == S_DONE) begin
            r_q      <= w_sh_nx;
            r_r      <= w_pr_nx[W-1:0];
            r_sticky <= |w_pr_nx[W-1:0];
            r_dz     <= 1'b0;
         end
      end
   end

   assign busy_o   = r_state != S_IDLE;
   assign valid_o  = r_state == S_DONE;
   assign q_o      = r_q;
   assign r_o      = r_r;
   assign sticky_o = r_sticky;
   assign dz_o     = r_dz;
endmodule

// File: tb/tb_fpu_mant_div.sv
// tb_fpu_mant_div: checks an 8/8 and a default 24/24 divider against an arithmetic model.
module tb_fpu_mant_div;
   logic clk = 1'b0;
   logic arst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   logic        start[2], abort[2], ack[2];
   logic [63:0] a_in[2], b_in[2];

   logic        bz8, v8, s8, d8, bz24, v24, s24, d24;
   logic [15:0] q8;
   logic [7:0]  r8;
   logic [47:0] q24;
   logic [23:0] r24;

   logic [63:0] oq[2], orr[2];
   logic        ov[2], obusy[2], os[2], od[2];
   assign oq[0] = {48'b0, q8};
   assign oq[1] = {16'b0, q24};
   assign orr[0] = {56'b0, r8};
   assign orr[1] = {40'b0, r24};
   assign ov[0] = v8;
   assign ov[1] = v24;
   assign obusy[0] = bz8;
   assign obusy[1] = bz24;
   assign os[0] = s8;
   assign os[1] = s24;
   assign od[0] = d8;
   assign od[1] = d24;

   fpu_mant_div #(.W(8), .F(8)) u_d8 (
      .clk(clk), .arst(arst), .start_i(start[0]), .abort_i(abort[0]),
      .a_i(a_in[0][7:0]), .b_i(b_in[0][7:0]), .ack_i(ack[0]),
      .busy_o(bz8), .valid_o(v8), .q_o(q8), .r_o(r8), .sticky_o(s8), .dz_o(d8)
   );

   fpu_mant_div u_d24 (
      .clk(clk), .arst(arst), .start_i(start[1]), .abort_i(abort[1]),
      .a_i(a_in[1][23:0]), .b_i(b_in[1][23:0]), .ack_i(ack[1]),
      .busy_o(bz24), .valid_o(v24), .q_o(q24), .r_o(r24), .sticky_o(s24), .dz_o(d24)
   );

   // expected result of the operation in flight, and the values outputs must hold otherwise
   logic [63:0] eq[2], er[2], hq[2], hr[2];
   logic        es[2], ed[2], hs[2], hd[2], pend[2], pv[2];
   int          stc[2], lat[2];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic void model(input int w, input int f, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] q, output logic [63:0] r);
      logic [63:0] num;
      num = a << f;
      if (b == 0) begin
         q = (64'd1 << (w + f)) - 64'd1;
         r = a;
      end else begin
         q = num / b;
         r = num % b;
      end
   endfunction

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!arst) begin
            hq[d] = '0; hr[d] = '0; hs[d] = 1'b0; hd[d] = 1'b0; pv[d] = 1'b0;
         end else begin
            if (ov[d]) begin
               if (!pv[d]) begin
                  chk($sformatf("latency%0d", d), 64'(cyc - stc[d]), 64'(lat[d]));
                  chk($sformatf("valid_allowed%0d", d), 64'(pend[d]), 64'd1);
               end
               chk($sformatf("q%0d", d), oq[d], eq[d]);
               chk($sformatf("r%0d", d), orr[d], er[d]);
               chk($sformatf("sticky%0d", d), 64'(os[d]), 64'(es[d]));
               chk($sformatf("dz%0d", d), 64'(od[d]), 64'(ed[d]));
               hq[d] = eq[d]; hr[d] = er[d]; hs[d] = es[d]; hd[d] = ed[d];
            end else begin
               chk($sformatf("q_hold%0d", d), oq[d], hq[d]);
               chk($sformatf("r_hold%0d", d), orr[d], hr[d]);
               chk($sformatf("sticky_hold%0d", d), 64'(os[d]), 64'(hs[d]));
               chk($sformatf("dz_hold%0d", d), 64'(od[d]), 64'(hd[d]));
            end
            pv[d] = ov[d];
         end
      end
   end

   // mode: 0 ack, 1 ack with start, 2 ack with abort, 3 abort alongside the start in IDLE
   task automatic op(input int d, input logic [63:0] a, input logic [63:0] b, input int dly,
                     input int mode, input bit now);
      int t;
      int w;
      w = d ? 24 : 8;
      if (!now) @(negedge clk);
      a_in[d] = a; b_in[d] = b; start[d] = 1'b1; abort[d] = (mode == 3);
      model(w, w, a, b, eq[d], er[d]);
      es[d] = er[d] != 0; ed[d] = b == 0;
      stc[d] = cyc; lat[d] = (b == 0) ? 2 : 2 * w + 2; pend[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0; abort[d] = 1'b0;
      a_in[d] = {$urandom, $urandom}; b_in[d] = {$urandom, $urandom};
      chk($sformatf("busy_run%0d", d), 64'(obusy[d]), 64'd1);
      t = 0;
      while (!ov[d] && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk($sformatf("valid_seen%0d", d), 64'(ov[d]), 64'd1);
      repeat (dly) @(negedge clk);
      chk($sformatf("valid_before_ack%0d", d), 64'(ov[d]), 64'd1);
      ack[d] = 1'b1; start[d] = (mode == 1); abort[d] = (mode == 2);
      @(negedge clk);
      ack[d] = 1'b0; start[d] = 1'b0; abort[d] = 1'b0; pend[d] = 1'b0;
      chk($sformatf("busy_after_ack%0d", d), 64'(obusy[d]), 64'd0);
   endtask

   initial begin
      logic [63:0] q, r, ra, rb;
      for (int d = 0; d < 2; d++) begin
         start[d] = 0; abort[d] = 0; ack[d] = 0; a_in[d] = 0; b_in[d] = 0;
         pend[d] = 0; stc[d] = 0; lat[d] = 0;
         eq[d] = 0; er[d] = 0; es[d] = 0; ed[d] = 0;
      end
      model(8, 8, 64'h80, 64'hC0, q, r);
      chk("pin_q_80_c0", q, 64'h00AA);
      chk("pin_r_80_c0", r, 64'h80);
      model(8, 8, 64'hFF, 64'h01, q, r);
      chk("pin_q_ff_01", q, 64'hFF00);
      model(8, 8, 64'h35, 64'h00, q, r);
      chk("pin_q_35_00", q, 64'hFFFF);
      chk("pin_r_35_00", r, 64'h35);
      model(24, 24, 64'h1, 64'h3, q, r);
      chk("pin_q24_1_3", q, 64'h555555);
      chk("pin_r24_1_3", r, 64'h1);

      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_busy%0d", d), 64'(obusy[d]), 64'd0);
         chk($sformatf("rst_valid%0d", d), 64'(ov[d]), 64'd0);
         chk($sformatf("rst_q%0d", d), oq[d], 64'd0);
         chk($sformatf("rst_r%0d", d), orr[d], 64'd0);
      end
      @(negedge clk);
      #1 arst = 1'b1;
      op(0, 64'h80, 64'hC0, 0, 0, 1'b1);
      op(0, 64'hFF, 64'h01, 5, 0, 1'b0);
      op(0, 64'h35, 64'h00, 0, 0, 1'b0);
      op(0, 64'h00, 64'h00, 1, 1, 1'b0);
      op(0, 64'h7F, 64'h03, 2, 2, 1'b0);
      op(0, 64'h01, 64'hFF, 0, 3, 1'b0);

      @(negedge clk);
      a_in[0] = 64'h5A; b_in[0] = 64'h07; start[0] = 1'b1; pend[0] = 1'b0;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (6) @(negedge clk);
      abort[0] = 1'b1;
      chk("busy_before_abort", 64'(obusy[0]), 64'd1);
      @(negedge clk);
      abort[0] = 1'b0;
      chk("busy_after_abort", 64'(obusy[0]), 64'd0);
      op(0, 64'hC3, 64'h0B, 1, 0, 1'b1);

      op(1, 64'h1, 64'h3, 0, 0, 1'b0);
      op(1, 64'hFFFFFF, 64'h1, 2, 0, 1'b0);
      op(1, 64'hFFFFFF, 64'hFFFFFF, 0, 0, 1'b0);
      op(1, 64'hABCDEF, 64'h0, 0, 0, 1'b0);

      for (int i = 0; i < 250; i++) begin
         ra = 64'($urandom_range(0, 255));
         rb = ($urandom_range(0, 7) == 0) ? 64'd0 : 64'($urandom_range(1, 255));
         op(0, ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      end
      for (int i = 0; i < 250; i++) begin
         ra = 64'($urandom & 32'hFFFFFF);
         rb = 64'($urandom & 32'hFFFFFF);
         if (rb == 0) rb = 64'd1;
         op(1, ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      end

      op(0, 64'h9D, 64'h05, 0, 0, 1'b0);
      @(negedge clk);
      a_in[1] = 64'h123456; b_in[1] = 64'h000777; start[1] = 1'b1; pend[1] = 1'b0;
      @(negedge clk);
      start[1] = 1'b0;
      repeat (10) @(negedge clk);
      @(posedge clk);
      #2 arst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("arst_busy%0d", d), 64'(obusy[d]), 64'd0);
         chk($sformatf("arst_valid%0d", d), 64'(ov[d]), 64'd0);
         chk($sformatf("arst_q%0d", d), oq[d], 64'd0);
         chk($sformatf("arst_r%0d", d), orr[d], 64'd0);
         chk($sformatf("arst_sticky%0d", d), 64'(os[d]), 64'd0);
         chk($sformatf("arst_dz%0d", d), 64'(od[d]), 64'd0);
      end
      @(negedge clk);
      #1 arst = 1'b1;
      op(1, 64'hFEDCBA, 64'h00ABCD, 0, 0, 1'b1);
      op(0, 64'hE1, 64'h1F, 0, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
